popcount_window_accumulator: RTL and testbench



---
 rtl/popcount_pkg.sv | 26 ++
 rtl/popcount_result_fifo.sv | 93 +++++++++
 rtl/popcount_window_accumulator.sv | 105 ++++++++++
 tb/tb_popcount_window_accumulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module   : popcount_pkg
// Brief    : Shared state encodings and width helper for the popcount pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1
    } acc_state_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Window total width: WINDOW * (2^cnt_w - 1) always fits.
    function automatic int sum_width(input int cnt_w, input int window);
        return cnt_w + $clog2(window);
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : popcount_result_fifo
// Brief    : Two-entry valid/ready result buffer with a discard (overrun) pulse.
// Revision : 1.0 - initial release
// ============================================================================
module popcount_result_fifo
    import popcount_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  overrun_o
);

    buf_state_t            r_state;
    buf_state_t            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;
    logic                  r_overrun;
    logic                  w_overrun_nxt;
    logic                  w_pop;

    assign valid_o   = (r_state == ONE) || (r_state == TWO);
    assign w_pop     = valid_o & pop_ready_i;
    assign data_o    = r_head;
    assign overrun_o = r_overrun;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state   <= EMPTY;
            r_head    <= '0;
            r_tail    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // The head register is cleared whenever the buffer drains so data_o reads 0.
    always_comb begin
        w_state_nxt   = r_state;
        w_head_nxt    = r_head;
        w_tail_nxt    = r_tail;
        w_overrun_nxt = 1'b0;
        case (r_state)
            EMPTY: begin
                if (push_i) begin
                    w_head_nxt  = push_data_i;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (push_i && w_pop) begin
                    w_head_nxt = push_data_i;
                end else if (push_i) begin
                    w_tail_nxt  = push_data_i;
                    w_state_nxt = TWO;
                end else if (w_pop) begin
                    w_head_nxt  = '0;
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_pop) begin
                    w_head_nxt  = r_tail;
                    w_tail_nxt  = push_i ? push_data_i : '0;
                    w_state_nxt = push_i ? TWO : ONE;
                end else if (push_i) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
                w_head_nxt  = '0;
                w_tail_nxt  = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/popcount_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : popcount_window_accumulator
// Brief    : Sums popcount results over windows of WINDOW samples and queues totals.
// Revision : 1.0 - initial release
// ============================================================================
module popcount_window_accumulator
    import popcount_pkg::*;
#(
    parameter int  CNT_WIDTH = 5,
    parameter int  WINDOW    = 8,
    localparam int SUM_WIDTH = sum_width(CNT_WIDTH, WINDOW),
    localparam int SMP_WIDTH = $clog2(WINDOW + 1)
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 cnt_val_i,
    input  logic                 flush_i,
    output logic [SUM_WIDTH-1:0] sum_o,
    output logic [SMP_WIDTH-1:0] samples_o,
    output logic                 sum_val_o,
    input  logic                 sum_ready_i,
    output logic                 overrun_o
);

    localparam logic [SMP_WIDTH-1:0] c_last_idx = SMP_WIDTH'(WINDOW - 1);

    acc_state_t           r_state;
    acc_state_t           w_state_nxt;
    logic [SUM_WIDTH-1:0] r_acc;
    logic [SUM_WIDTH-1:0] w_acc_nxt;
    logic [SUM_WIDTH-1:0] w_sample;
    logic [SUM_WIDTH-1:0] w_total;
    logic [SMP_WIDTH-1:0] r_count;
    logic [SMP_WIDTH-1:0] w_count_nxt;
    logic [SMP_WIDTH-1:0] w_samples;
    logic                 w_close;

    // The closing sample is folded into the emitted total.
    assign w_sample  = cnt_val_i ? SUM_WIDTH'(cnt_i) : '0;
    assign w_total   = r_acc + w_sample;
    assign w_samples = r_count + SMP_WIDTH'(cnt_val_i);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_close     = 1'b0;
        case (r_state)
            IDLE: begin
                // WINDOW >= 2, so only a flush can close on the first sample.
                w_close = cnt_val_i & flush_i;
                if (cnt_val_i && !flush_i) begin
                    w_acc_nxt   = w_total;
                    w_count_nxt = w_samples;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                w_close = flush_i || (cnt_val_i && (r_count == c_last_idx));
                if (w_close) begin
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (cnt_val_i) begin
                    w_acc_nxt   = w_total;
                    w_count_nxt = w_samples;
                end
            end
            default: begin
                w_acc_nxt   = '0;
                w_count_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    popcount_result_fifo #(
        .DATA_WIDTH (SMP_WIDTH + SUM_WIDTH)
    ) u_result_fifo (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .push_i      (w_close),
        .push_data_i ({w_samples, w_total}),
        .pop_ready_i (sum_ready_i),
        .data_o      ({samples_o, sum_o}),
        .valid_o     (sum_val_o),
        .overrun_o   (overrun_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_popcount_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount_window_accumulator
// Brief    : Scoreboard bench for the popcount window accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_popcount_window_accumulator;

    localparam int CNT_W = 5;
    localparam int WIN   = 4;
    localparam int SUM_W = 7;
    localparam int SMP_W = 3;

    logic             clk_i       = 1'b0;
    logic             arst_n_i    = 1'b0;
    logic [CNT_W-1:0] cnt_i       = '0;
    logic             cnt_val_i   = 1'b0;
    logic             flush_i     = 1'b0;
    logic             sum_ready_i = 1'b0;
    logic [SUM_W-1:0] sum_o;
    logic [SMP_W-1:0] samples_o;
    logic             sum_val_o;
    logic             overrun_o;

    always #5 clk_i = ~clk_i;

    popcount_window_accumulator #(
        .CNT_WIDTH (CNT_W),
        .WINDOW    (WIN)
    ) dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cnt_i       (cnt_i),
        .cnt_val_i   (cnt_val_i),
        .flush_i     (flush_i),
        .sum_o       (sum_o),
        .samples_o   (samples_o),
        .sum_val_o   (sum_val_o),
        .sum_ready_i (sum_ready_i),
        .overrun_o   (overrun_o)
    );

    typedef struct {
        int tot;
        int smp;
    } res_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];
    int   win_q[$];
    int   occ      = 0;
    bit   ovr_flag = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: a window is a list of samples; the output buffer holds at most two totals.
    task automatic step(input bit v, input int c, input bit f, input bit r);
        bit close;
        bit pop;
        res_t item;
        cnt_val_i   = v;
        cnt_i       = CNT_W'(c);
        flush_i     = f;
        sum_ready_i = r;
        @(posedge clk_i);
        close = (v && (win_q.size() + 1 == WIN)) || (f && (win_q.size() > 0 || v));
        pop   = (occ > 0) && r;
        if (v) win_q.push_back(c);
        ovr_flag = 1'b0;
        if (pop) occ--;
        if (close) begin
            if (occ < 2) begin
                item.tot = win_q.sum();
                item.smp = win_q.size();
                exp_q.push_back(item);
                occ++;
            end else begin
                ovr_flag = 1'b1;
            end
            win_q.delete();
        end
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, r);
    endtask

    task automatic do_reset();
        #2 arst_n_i = 1'b0;
        #1;
        check("rst_sum", int'(sum_o), 0);
        check("rst_samples", int'(samples_o), 0);
        check("rst_val", int'(sum_val_o), 0);
        check("rst_overrun", int'(overrun_o), 0);
        win_q.delete();
        exp_q.delete();
        occ       = 0;
        ovr_flag  = 1'b0;
        cnt_val_i = 1'b0;
        flush_i   = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 arst_n_i = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (arst_n_i) begin
                check("sum_val", int'(sum_val_o), int'(exp_q.size() > 0));
                if (ovr_flag || overrun_o) check("overrun", int'(overrun_o), int'(ovr_flag));
                if (sum_val_o && exp_q.size() > 0) begin
                    check("sum", int'(sum_o), exp_q[0].tot);
                    check("samples", int'(samples_o), exp_q[0].smp);
                    if (sum_ready_i) void'(exp_q.pop_front());
                end else if (!sum_val_o) begin
                    check("empty_sum", int'(sum_o), 0);
                    check("empty_samples", int'(samples_o), 0);
                end
            end
        end
    end

    initial begin : driver
        int gap;
        @(posedge clk_i);
        #1;
        check("init_sum", int'(sum_o), 0);
        check("init_samples", int'(samples_o), 0);
        check("init_val", int'(sum_val_o), 0);
        check("init_overrun", int'(overrun_o), 0);
        @(posedge clk_i);
        #1 arst_n_i = 1'b1;

        // Back-to-back window 3,5,7,1.
        step(1, 3, 0, 1); step(1, 5, 0, 1); step(1, 7, 0, 1); step(1, 1, 0, 1);
        idle(3, 1'b1);

        // Same values with random gaps, then 2,9 and a lone flush.
        step(1, 3, 0, 1); idle($urandom_range(0, 3), 1'b1);
        step(1, 5, 0, 1); idle($urandom_range(0, 3), 1'b1);
        step(1, 7, 0, 1); idle($urandom_range(0, 3), 1'b1);
        step(1, 1, 0, 1);
        step(1, 2, 0, 1); step(1, 9, 0, 1);
        step(0, 0, 1, 1);
        idle(2, 1'b1);

        // Flush while idle, then flush together with the 4th sample.
        step(0, 0, 1, 1);
        idle(3, 1'b1);
        step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 0, 1); step(1, 4, 1, 1);
        idle(3, 1'b1);

        // Three all-ones windows with no consumer: third one is dropped.
        for (int i = 0; i < 3 * WIN; i++) step(1, 31, 0, 0);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // Simultaneous push and pop in ONE, then in TWO.
        for (int i = 0; i < WIN; i++) step(1, $urandom_range(0, 31), 0, 0);
        for (int i = 0; i < WIN - 1; i++) step(1, $urandom_range(0, 31), 0, 0);
        step(1, $urandom_range(0, 31), 0, 1);
        idle(2, 1'b0);
        for (int i = 0; i < WIN - 1; i++) step(1, $urandom_range(0, 31), 0, 0);
        step(1, $urandom_range(0, 31), 0, 0);
        for (int i = 0; i < WIN - 1; i++) step(1, $urandom_range(0, 31), 0, 0);
        step(1, $urandom_range(0, 31), 0, 1);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Reset with a partial window, then with a full buffer.
        step(1, 1, 0, 1); step(1, 2, 0, 1);
        do_reset();
        for (int i = 0; i < 2 * WIN; i++) step(1, $urandom_range(0, 31), 0, 0);
        do_reset();
        step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
        idle(3, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            gap = $urandom_range(0, 9);
            step(gap < 6, $urandom_range(0, 31), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1);
        end
        idle(5, 1'b1);
        check("drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
